// File: rtl/video_dnn_pkg.sv
// Shared definitions for the video DNN post-processing blocks.
package video_dnn_pkg;

  // Default class layout: 0-9 are digits, 10 is the non-digit class.
  localparam int DEF_NUM_CLASS     = 11;
  localparam int CLASS_NON_DIGIT   = 10;
  localparam int DEF_TNUMBER_WIDTH = 4;

  // Bit of tuser carrying start-of-frame.
  localparam int SOF_BIT = 0;

  // Result serializer state.
  typedef enum logic [0:0] {
    OUT_IDLE = 1'b0,
    OUT_SEND = 1'b1
  } out_state_e;

endpackage

// File: rtl/video_dnn_class_histogram_out.sv
// Result side of the class histogram: shadow copy of one frame's counts,
// the word serializer FSM and the registered AXI4-Stream output slice.
//
// Handshake: a word transfers on a rising clock edge where m_axi4s_tvalid
// and m_axi4s_tready are both high; while tvalid is high and tready is low
// every m_* output holds its value.  load is only asserted by the
// accumulator when free is high in the same cycle.
module video_dnn_class_histogram_out
  import video_dnn_pkg::*;
#(
  parameter int NUM_CLASS     = DEF_NUM_CLASS,
  parameter int TNUMBER_WIDTH = DEF_TNUMBER_WIDTH,
  parameter int COUNT_WIDTH   = 20
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     load,
  input  logic [COUNT_WIDTH-1:0]   load_data [NUM_CLASS],
  output logic                     free,
  output out_state_e               state,
  output logic                     m_axi4s_tuser,
  output logic                     m_axi4s_tlast,
  output logic [TNUMBER_WIDTH-1:0] m_axi4s_tclass,
  output logic [COUNT_WIDTH-1:0]   m_axi4s_tdata,
  output logic                     m_axi4s_tvalid,
  input  logic                     m_axi4s_tready
);

  localparam logic [TNUMBER_WIDTH-1:0] LAST_CLASS = TNUMBER_WIDTH'(NUM_CLASS - 1);

  logic [COUNT_WIDTH-1:0]   shadow [NUM_CLASS];
  logic [TNUMBER_WIDTH-1:0] next_class;
  logic                     word_done;

  assign next_class = m_axi4s_tclass + TNUMBER_WIDTH'(1);
  assign word_done  = m_axi4s_tvalid & m_axi4s_tready;

  // The shadow is reusable while idle or when the final word leaves this cycle.
  assign free = (state == OUT_IDLE) | (word_done & m_axi4s_tlast);

  // Serializer FSM with registered outputs; a load always restarts at class 0.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state          <= OUT_IDLE;
      m_axi4s_tvalid <= 1'b0;
      m_axi4s_tuser  <= 1'b0;
      m_axi4s_tlast  <= 1'b0;
      m_axi4s_tclass <= '0;
      m_axi4s_tdata  <= '0;
      for (int i = 0; i < NUM_CLASS; i++) begin
        shadow[i] <= '0;
      end
    end else if (load) begin
      state          <= OUT_SEND;
      m_axi4s_tvalid <= 1'b1;
      m_axi4s_tuser  <= 1'b1;
      m_axi4s_tlast  <= (NUM_CLASS == 1);
      m_axi4s_tclass <= '0;
      m_axi4s_tdata  <= load_data[0];
      for (int i = 0; i < NUM_CLASS; i++) begin
        shadow[i] <= load_data[i];
      end
    end else if (state == OUT_SEND && word_done) begin
      if (m_axi4s_tlast) begin
        state          <= OUT_IDLE;
        m_axi4s_tvalid <= 1'b0;
        m_axi4s_tuser  <= 1'b0;
        m_axi4s_tlast  <= 1'b0;
        m_axi4s_tclass <= '0;
        m_axi4s_tdata  <= '0;
      end else begin
        m_axi4s_tuser  <= 1'b0;
        m_axi4s_tlast  <= (next_class == LAST_CLASS);
        m_axi4s_tclass <= next_class;
        m_axi4s_tdata  <= shadow[next_class];
      end
    end
  end

endmodule

// File: rtl/video_dnn_class_histogram.sv
// Per-frame class histogram sink: counts pixels per class over each frame
// of the classification stream and hands the counts to the result
// serializer at frame end.  The video input is never stalled.
module video_dnn_class_histogram
  import video_dnn_pkg::*;
#(
  parameter int NUM_CLASS     = DEF_NUM_CLASS,
  parameter int TNUMBER_WIDTH = DEF_TNUMBER_WIDTH,
  parameter int TUSER_WIDTH   = 1,
  parameter int COUNT_WIDTH   = 20,
  parameter int IMG_Y_WIDTH   = 10,
  parameter int DROP_WIDTH    = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [IMG_Y_WIDTH-1:0]   param_height,
  input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
  input  logic                     s_axi4s_tlast,
  input  logic [TNUMBER_WIDTH-1:0] s_axi4s_tnumber,
  input  logic                     s_axi4s_tvalid,
  output logic                     s_axi4s_tready,
  output logic                     m_axi4s_tuser,
  output logic                     m_axi4s_tlast,
  output logic [TNUMBER_WIDTH-1:0] m_axi4s_tclass,
  output logic [COUNT_WIDTH-1:0]   m_axi4s_tdata,
  output logic                     m_axi4s_tvalid,
  input  logic                     m_axi4s_tready,
  output logic [DROP_WIDTH-1:0]    out_drop_count
);

  logic [COUNT_WIDTH-1:0] cnt      [NUM_CLASS];
  logic [COUNT_WIDTH-1:0] cnt_next [NUM_CLASS];
  logic [IMG_Y_WIDTH-1:0] line_q;
  logic [IMG_Y_WIDTH-1:0] height_q;
  logic [IMG_Y_WIDTH-1:0] eff_line;
  logic [IMG_Y_WIDTH-1:0] eff_height;
  logic                   in_frame_q;
  logic                   sof;
  logic                   active;
  logic                   frame_end;
  logic                   out_free;
  logic                   out_load;
  out_state_e             out_state;

  // An SOF pixel starts a fresh frame, so it sees line 0 and the new height.
  assign sof        = s_axi4s_tvalid & s_axi4s_tuser[SOF_BIT];
  assign active     = s_axi4s_tvalid & (sof | in_frame_q);
  assign eff_line   = sof ? '0 : line_q;
  assign eff_height = sof ? param_height : height_q;
  assign frame_end  = active & s_axi4s_tlast & (eff_line == eff_height - IMG_Y_WIDTH'(1));
  assign out_load   = frame_end & out_free;

  // Next counter values: cleared by SOF, bumped by the pixel's class, saturating.
  always_comb begin
    for (int i = 0; i < NUM_CLASS; i++) begin
      cnt_next[i] = sof ? '0 : cnt[i];
      if (active && s_axi4s_tnumber == TNUMBER_WIDTH'(i) && cnt_next[i] != '1) begin
        cnt_next[i] = cnt_next[i] + COUNT_WIDTH'(1);
      end
    end
  end

  // Live counters: clear at frame end whether the counts were loaded or dropped.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_CLASS; i++) begin
        cnt[i] <= '0;
      end
    end else if (frame_end) begin
      for (int i = 0; i < NUM_CLASS; i++) begin
        cnt[i] <= '0;
      end
    end else if (active) begin
      for (int i = 0; i < NUM_CLASS; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  // Frame tracking: line counter, latched height and the in-frame flag.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      in_frame_q <= 1'b0;
      line_q     <= '0;
      height_q   <= '0;
    end else begin
      if (sof) begin
        height_q <= param_height;
      end
      if (frame_end) begin
        in_frame_q <= 1'b0;
      end else if (sof) begin
        in_frame_q <= 1'b1;
      end
      if (sof) begin
        line_q <= s_axi4s_tlast ? IMG_Y_WIDTH'(1) : '0;
      end else if (active && s_axi4s_tlast) begin
        line_q <= line_q + IMG_Y_WIDTH'(1);
      end
    end
  end

  // Dropped-frame counter: a frame ending while the shadow is busy is lost.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      out_drop_count <= '0;
    end else if (frame_end && !out_free && out_drop_count != '1) begin
      out_drop_count <= out_drop_count + DROP_WIDTH'(1);
    end
  end

  // Input is always accepted once out of reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s_axi4s_tready <= 1'b0;
    end else begin
      s_axi4s_tready <= 1'b1;
    end
  end

  video_dnn_class_histogram_out #(
    .NUM_CLASS     (NUM_CLASS),
    .TNUMBER_WIDTH (TNUMBER_WIDTH),
    .COUNT_WIDTH   (COUNT_WIDTH)
  ) u_out (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .load           (out_load),
    .load_data      (cnt_next),
    .free           (out_free),
    .state          (out_state),
    .m_axi4s_tuser  (m_axi4s_tuser),
    .m_axi4s_tlast  (m_axi4s_tlast),
    .m_axi4s_tclass (m_axi4s_tclass),
    .m_axi4s_tdata  (m_axi4s_tdata),
    .m_axi4s_tvalid (m_axi4s_tvalid),
    .m_axi4s_tready (m_axi4s_tready)
  );

  // Serializer state is kept visible here for checkers bound to this level.
  out_state_e out_state_dbg;
  assign out_state_dbg = out_state;

endmodule

// File: doc/video_dnn_class_histogram.md
# video_dnn_class_histogram

Per-frame class histogram sink for the semantic-segmentation pipeline. It consumes the per-pixel classification stream produced by `video_dnn_max_count` (`tuser`, `tlast`, `tnumber`, `tvalid`, `tready`) and counts pixels per class over each frame. At frame end it emits the counts as a short AXI4-Stream burst, one word per class, for software or a CPU-side reader. The video input is never stalled; result output is double-buffered against accumulation of the next frame.

## Interface
Parameters:
- `NUM_CLASS`, 11, number of classes; 0–9 are digits, 10 is non-digit.
- `TNUMBER_WIDTH`, 4, width of the class index.
- `TUSER_WIDTH`, 1, width of `tuser`; bit 0 is start-of-frame (SOF).
- `COUNT_WIDTH`, 20, width of each pixel counter.
- `IMG_Y_WIDTH`, 10, width of the line counter and of `param_height`.
- `DROP_WIDTH`, 16, width of the dropped-frame counter.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  synchronous, active-low reset.
- `param_height`  in  IMG_Y_WIDTH  lines per frame; sampled only at SOF.
- `s_axi4s_tuser`  in  TUSER_WIDTH  bit 0 = SOF.
- `s_axi4s_tlast`  in  1  end of line.
- `s_axi4s_tnumber`  in  TNUMBER_WIDTH  class of the pixel.
- `s_axi4s_tvalid`  in  1  pixel valid.
- `s_axi4s_tready`  out  1  constant 1 once out of reset.
- `m_axi4s_tuser`  out  1  high on the class-0 word.
- `m_axi4s_tlast`  out  1  high on the class NUM_CLASS-1 word.
- `m_axi4s_tclass`  out  TNUMBER_WIDTH  class index of the word.
- `m_axi4s_tdata`  out  COUNT_WIDTH  pixel count.
- `m_axi4s_tvalid`  out  1  result word valid.
- `m_axi4s_tready`  in  1  result word accepted.
- `out_drop_count`  out  DROP_WIDTH  saturating count of frames whose results were dropped.

## Operation
- A pixel is accepted when `s_axi4s_tvalid` is high; `tready` is always 1.
- Pixels accepted before the first SOF after reset are ignored.
- **SOF handshake.** Clears all counters, sets the line counter to 0, sets `in_frame`, and latches `param_height`. The SOF pixel itself is counted.
- **SOF while `in_frame` (short frame).** The partial frame is discarded silently and the new frame starts.
- **Class counting.** `tnumber < NUM_CLASS` increments `cnt[tnumber]`. Any other value is ignored. Counters saturate at all-ones.
- **Line counting.** A `tlast` handshake increments the line counter.
- **Frame end.** Occurs on a `tlast` handshake while `in_frame` and line == latched height − 1. It clears `in_frame`.
- **Transfer to shadow.** At frame end, if the shadow is free, `shadow[i] <= cnt[i]`, including the final pixel's increment in the same cycle, and the live counters clear.
  - The shadow counts as free when the serializer is idle, or when it is completing its last word this same cycle (`m_tvalid & m_tready & m_tlast`).
- **Drop.** If the shadow is not free at frame end, the frame's counts are discarded and `out_drop_count` increments (saturating).
- **Serializer states.**
  - IDLE → SEND on a shadow load.
  - SEND outputs words for class 0..NUM_CLASS-1, advancing on each `m_tvalid & m_tready`.
  - SEND → IDLE after the `tlast` word, or → SEND with a fresh load on the simultaneous-free case.
- A SOF arriving in the same cycle as frame end is impossible, because they fall on different pixels. Frame end and the next frame's SOF on consecutive pixels must both be honoured.
- **Reset.** While `aresetn` is low at a clock edge: all counters, shadow, `in_frame` and `out_drop_count` go to 0; the serializer goes to IDLE. This applies mid-frame and mid-burst, and the burst is abandoned.

## Timing
- Reset values:
  - `s_axi4s_tready` = 0 during reset, 1 from the first cycle after release.
  - `m_axi4s_tvalid`, `m_axi4s_tuser`, `m_axi4s_tlast` = 0.
  - `m_axi4s_tclass`, `m_axi4s_tdata` = 0.
  - `out_drop_count` = 0.
- Frame end at edge T → `m_tvalid` = 1 with the class-0 word from T+1.
- With `m_tready` held high, the burst lasts NUM_CLASS cycles.
- All `m_*` outputs are registered.
- When `tvalid & !tready`, every `m_*` output holds stable.
- Counters update at the edge following each accepted pixel. There is no input-side latency visible to the stream.

## Structure
- Shared package `video_dnn_pkg`: `NUM_CLASS` default, `CLASS_NON_DIGIT = 10`, `TNUMBER_WIDTH` default, SOF bit index.
- Sub-module `video_dnn_class_histogram_out`:
  - contains the shadow register array, the serializer FSM and the output register slice;
  - provides a `load`/`free` interface to the accumulator.
- The top level holds the accumulator, the line counter, frame tracking and the drop counter.

## Test plan
- **Basic frame.** 4×2 frame (`param_height` = 2), classes {0,0,3,10,10,10,15,3}, `m_tready` = 1.
  - Expect 11 words, `tuser` on class 0 and `tlast` on class 10.
  - Counts: class 0 = 2, class 3 = 2, class 10 = 3, others 0. Class 15 is ignored.
  - First word appears 1 cycle after the final pixel.
- **Back-pressure and drop.** `m_tready` = 0 across two complete frames.
  - Frame 1 is held stable; frame 2 is dropped and `out_drop_count` = 1.
  - Releasing `tready` delivers frame 1's counts.
- **Simultaneous free.** Frame end in the same cycle the last word handshakes.
  - The new counts load, `tvalid` stays high without a gap, and `out_drop_count` is unchanged.
- **Short frame.** SOF after 1 of 2 lines.
  - No output for the partial frame; the next full frame reports only its own pixels.
- **Saturation.** COUNT_WIDTH = 4, 20 pixels of class 5 → class 5 reports 15.
- **Reset mid-burst.** Reset asserted after word 3 of a burst.
  - `m_tvalid` = 0 next cycle and `out_drop_count` = 0.
  - Pixels before the next SOF produce no output.
